restoring_divider: RTL
======================

// Module: restoring_divider
// PURPOSE
//  Sequential unsigned radix-2 restoring divider: the inverse-direction companion
//  to the Booth shift/add multiplier. It computes dividend / divisor, one quotient
//  bit per clock. It contains its own control FSM and an A/Q shift-register datapath.
//  It sits beside the multiplier in the arithmetic unit and uses a start/done
//  handshake.
// PARAMETERS
//  WIDTH   16   operand, quotient and remainder width in bits (>= 2)
// PORTS
//  clk          in   1      single clock; every register updates on posedge clk
//  rst          in   1      reset, synchronous, active-high
//  start        in   1      request; sampled only when busy==0
//  dividend     in   WIDTH  sampled on the accepting start edge only
//  divisor      in   WIDTH  sampled on the accepting start edge only
//  busy         out  1      high while an iteration is in progress
//  done         out  1      one-cycle pulse: result valid
//  div_by_zero  out  1      valid with done; held until the next accepted start
//  quotient     out  WIDTH  result; held stable from done until the next accepted start
//  remainder    out  WIDTH  result; held stable from done until the next accepted start
// BEHAVIOUR
//  Reset: state=IDLE. busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, count=0.
//   rst takes priority over every other input, including mid-operation.
//   A division in progress is abandoned and no done is produced.
//  FSM states: IDLE, ITER, DONE.
//   IDLE or DONE, start=1, divisor!=0: Q<=dividend, A<=0, M<=divisor,
//    count<=WIDTH, go to ITER.
//   IDLE or DONE, start=1, divisor==0: no iteration.
//    quotient<={WIDTH{1'b1}}, remainder<=dividend, div_by_zero<=1, go to DONE.
//   ITER, each cycle:
//    {A,Q} <= {A,Q}<<1.
//    T = A_shifted - {1'b0,M}. A is WIDTH+1 bits; bit WIDTH is the sign.
//    If T[WIDTH]==0: A<=T and Q[0]<=1. Otherwise A is restored (A_shifted kept)
//     and Q[0]<=0.
//    count<=count-1. When count==1 at this edge, go to DONE.
//   DONE: done=1 for exactly this one cycle. quotient=Q, remainder=A[WIDTH-1:0].
//    Next state is IDLE, or ITER/DONE if start is asserted in this cycle.
//    Back-to-back operation is therefore allowed.
//  Latency: call the cycle in which start is accepted cycle 0.
//   Normal operation: done is high in cycle WIDTH+1.
//   Divide-by-zero: done is high in cycle 1.
//  busy: high in ITER only. start while busy is ignored and does not corrupt the
//   in-flight operation.
//  div_by_zero: cleared on the next accepted start that has divisor!=0.
//  Results: never change while busy. Internal A/Q registers are not visible
//   until DONE.
//  Width: A is WIDTH+1 bits, Q and M are WIDTH bits, count is $clog2(WIDTH+1) bits.
//   Operands are unsigned; no signed mode.
//  Boundaries: dividend<divisor gives q=0, r=dividend. dividend==divisor gives q=1,
//   r=0. divisor==1 gives q=dividend, r=0. dividend=0 gives q=0, r=0
//   (full WIDTH iterations still run).
// STRUCTURE
//  Shared package/include div_defs: state encoding localparams (IDLE=2'd0,
//   ITER=2'd1, DONE=2'd2) and the DIV_WIDTH default. The multiplier control reuses
//   the same style.
//  One sub-module: restoring_div_dp, the datapath holding the A/Q/M registers,
//   subtractor and count.
//   Inputs: ld, shift_sub, clr.
//   Outputs: count_is_one, the result buses.
//  The FSM stays in the top-level restoring_divider.
// TESTING
//  1. 100/7, WIDTH=16 -> done in cycle 17, q=14, r=2, div_by_zero=0;
//     busy high in cycles 1..16.
//  2. 16'hFFFF/16'h0001 -> q=16'hFFFF, r=0; then 16'h0003/16'h000A -> q=0, r=3.
//  3. 5/0 -> done in cycle 1, div_by_zero=1, q=16'hFFFF, r=5.
//     A following 9/3 -> div_by_zero=0, q=3, r=0.
//  4. Start 1000/10, then assert start with 7/7 in cycles 3..10 -> ignored;
//     done in cycle 17 with q=100, r=0. Then start 7/7 in the DONE cycle ->
//     next done 17 cycles later with q=1, r=0.
//  5. Start 50000/3, assert rst in cycle 8 -> next cycle all outputs 0,
//     state IDLE, no done pulse.
//  6. Random unsigned operands vs. golden model (/ and %), with back-to-back starts.
//     Expect every result and done timing to match.

Source files
------------

// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the sequential divider: controller state encoding and
// default operand width.
package restoring_divider_pkg;

  localparam int DIV_WIDTH = 16;

  // state | meaning
  // IDLE  | waiting for start, results held
  // ITER  | one quotient bit per cycle, busy high
  // DONE  | one-cycle done pulse, results valid
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/restoring_divider_if.sv
// Start/done handshake and operand/result bus of the divider.
interface restoring_divider_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_by_zero, quotient, remainder
  );

endinterface

// File: rtl/restoring_div_dp.sv
// Datapath of the restoring divider: A/Q shift pair, divisor M, iteration
// counter and the result registers that stay frozen while iterating.
module restoring_div_dp #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic             shift_sub,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             count_is_one,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH:0]   a;
  logic [WIDTH:0]   a_nxt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    count;
  // One guard bit above the shifted A keeps the sign of the trial result
  // exact; the stored A top bit is always clear after restore/accept.
  logic [WIDTH+1:0] trial;

  assign count_is_one = (count == CW'(1));

  // Shift {A,Q} left, trial-subtract M, restore on a negative result
  always_comb begin
    trial = {a, q[WIDTH-1]} - {2'b00, m};
    if (!trial[WIDTH+1]) begin
      a_nxt = trial[WIDTH:0];
      q_nxt = {q[WIDTH-2:0], 1'b1};
    end else begin
      a_nxt = {a[WIDTH-1:0], q[WIDTH-1]};
      q_nxt = {q[WIDTH-2:0], 1'b0};
    end
  end

  // Operand load, iteration update and result capture on the final step
  always_ff @(posedge clk) begin
    if (clr) begin
      a           <= '0;
      q           <= '0;
      m           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (ld) begin
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        a           <= '0;
        q           <= dividend;
        m           <= divisor;
        count       <= CW'(WIDTH);
        div_by_zero <= 1'b0;
      end
    end else if (shift_sub) begin
      a     <= a_nxt;
      q     <= q_nxt;
      count <= count - CW'(1);
      if (count_is_one) begin
        quotient  <= q_nxt;
        remainder <= a_nxt[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned radix-2 restoring divider with start/done handshake.
// Control FSM lives here; arithmetic lives in restoring_div_dp.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  restoring_divider_if.slave bus
);

  div_state_t state;
  div_state_t state_nxt;
  logic       ld;
  logic       shift_sub;
  logic       count_is_one;
  logic       divisor_zero;

  assign divisor_zero = (bus.divisor == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and datapath controls; start is only honoured outside ITER
  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    shift_sub = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE, DONE: begin
        bus.done  = (state == DONE);
        state_nxt = IDLE;
        if (bus.start) begin
          ld        = 1'b1;
          state_nxt = divisor_zero ? DONE : ITER;
        end
      end
      ITER: begin
        bus.busy  = 1'b1;
        shift_sub = 1'b1;
        if (count_is_one) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  restoring_div_dp #(.WIDTH(WIDTH)) u_dp (
    .clk          (clk),
    .clr          (rst),
    .ld           (ld),
    .shift_sub    (shift_sub),
    .dividend     (bus.dividend),
    .divisor      (bus.divisor),
    .count_is_one (count_is_one),
    .quotient     (bus.quotient),
    .remainder    (bus.remainder),
    .div_by_zero  (bus.div_by_zero)
  );

endmodule
